// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
//
// Drains the two virtual-channel FIFOs (VC0, VC1) and forwards every word to
// one of two destination FIFOs (D0, D1). The destination is chosen by bit
// DEST_BIT of the word: 0 routes to D0, 1 routes to D1.
//
// Pipeline (pop -> push latency is 2 cycles):
//   cycle N   : pop_vc0/pop_vc1 asserted (combinational rd_enable)
//   cycle N+1 : s1_valid/s1_sel hold the popped source; the VC FIFO presents
//               its registered read data on data_vc0/data_vc1
//   cycle N+2 : data_out and push_d0/push_d1 are driven from registers
//
// Pops require both destination almost-full flags to be low, because the
// destination of a word is unknown until its data arrives. Up to two words
// may already be in flight when almost-full rises, so the destination FIFOs
// must keep at least two free slots below their almost-full threshold.
//
// Optional build macro:
//   VC_ARB_ROUND_ROBIN_EN - when defined, VC0 and VC1 alternate whenever both
//                           are non-empty (VC0 wins first after reset/init).
//                           When undefined, VC0 has strict priority.
//
// Ports:
//   clk            in   single clock, everything on posedge
//   reset          in   synchronous active-high reset
//   init           in   low = hold in INIT and flush pipeline/counters
//   empty_vc0/1    in   VC FIFO empty flags
//   data_vc0/1     in   VC FIFO registered read data (valid cycle after pop)
//   almost_full_d0/1 in destination FIFO almost-full flags
//   pop_vc0/1      out  VC FIFO rd_enable (combinational)
//   push_d0/1      out  destination FIFO wr_enable (registered)
//   data_out       out  word to destination FIFOs (registered)
//   state          out  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3
//   idle           out  IDLE with nothing in flight
//   cnt_d0/1       out  words pushed per destination, wrapping
// -----------------------------------------------------------------------------
module vc_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int DEST_BIT   = 4,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic                  empty_vc0,
   input  logic                  empty_vc1,
   input  logic [DATA_WIDTH-1:0] data_vc0,
   input  logic [DATA_WIDTH-1:0] data_vc1,
   input  logic                  almost_full_d0,
   input  logic                  almost_full_d1,
   output logic                  pop_vc0,
   output logic                  pop_vc1,
   output logic                  push_d0,
   output logic                  push_d1,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [1:0]            state,
   output logic                  idle,
   output logic [CNT_WIDTH-1:0]  cnt_d0,
   output logic [CNT_WIDTH-1:0]  cnt_d1
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_r;
   state_t                  state_next;

   // Stage 1: a pop was issued last cycle; s1_sel remembers which VC it hit.
   logic                    s1_valid;
   logic                    s1_sel;
   logic [DATA_WIDTH-1:0]   s1_word;

   // Reset and a low init both discard everything in flight.
   logic                    flush;
   logic                    serving;
   logic                    go;

   assign flush   = reset || !init;
   assign serving = (state_r == ST_IDLE) || (state_r == ST_ACTIVE);
   assign go      = !almost_full_d0 && !almost_full_d1;
   assign state   = state_r;

   // The VC FIFO read data is registered inside the FIFO, so the word for a
   // stage-1 entry is simply whichever data bus its source presents now.
   assign s1_word = s1_sel ? data_vc1 : data_vc0;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= state_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic (reset, then init, then the normal transitions)
   // --------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state_r;
      if (reset) begin
         state_next = ST_RESET;
      end else if (!init) begin
         state_next = ST_INIT;
      end else begin
         case (state_r)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT:   state_next = ST_IDLE;
            ST_IDLE: begin
               if (!empty_vc0 || !empty_vc1) begin
                  state_next = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // Stay active until the last popped word has left stage 1.
               if (empty_vc0 && empty_vc1 && !s1_valid) begin
                  state_next = ST_IDLE;
               end
            end
            default:   state_next = ST_RESET;
         endcase
      end
   end

`ifdef VC_ARB_ROUND_ROBIN_EN
   // --------------------------------------------------------------------------
   // Round-robin history: 1 = VC1 served last. Starting at VC1 lets VC0 win
   // the first contended cycle.
   // --------------------------------------------------------------------------
   logic last_vc1;

   always_ff @(posedge clk) begin
      if (flush) begin
         last_vc1 <= 1'b1;
      end else if (pop_vc0) begin
         last_vc1 <= 1'b0;
      end else if (pop_vc1) begin
         last_vc1 <= 1'b1;
      end
   end
`endif

   // --------------------------------------------------------------------------
   // FSM: outputs (pop selection and idle)
   // --------------------------------------------------------------------------
   always_comb begin
      pop_vc0 = 1'b0;
      pop_vc1 = 1'b0;
      if (serving && go) begin
`ifdef VC_ARB_ROUND_ROBIN_EN
         if (!empty_vc0 && !empty_vc1) begin
            pop_vc0 = last_vc1;
            pop_vc1 = !last_vc1;
         end else begin
            pop_vc0 = !empty_vc0;
            pop_vc1 = !empty_vc1;
         end
`else
         pop_vc0 = !empty_vc0;
         pop_vc1 = empty_vc0 && !empty_vc1;
`endif
      end
      idle = (state_r == ST_IDLE) && !s1_valid && !push_d0 && !push_d1;
   end

   // --------------------------------------------------------------------------
   // Stage 1: remember that a pop happened and from which VC.
   // --------------------------------------------------------------------------
   // NOTE: only the control bits (valid/select) strictly need clearing to drop
   // in-flight words; the word itself is never stored here, it is taken
   // straight from the FIFO's read register.
   always_ff @(posedge clk) begin
      if (flush) begin
         s1_valid <= 1'b0;
         s1_sel   <= 1'b0;
      end else begin
         s1_valid <= pop_vc0 || pop_vc1;
         s1_sel   <= pop_vc1;
      end
   end

   // --------------------------------------------------------------------------
   // Stage 2: capture the word and raise exactly one destination push.
   // data_out returns to zero on cycles without a transfer.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (flush) begin
         push_d0  <= 1'b0;
         push_d1  <= 1'b0;
         data_out <= '0;
      end else if (s1_valid) begin
         push_d0  <= !s1_word[DEST_BIT];
         push_d1  <= s1_word[DEST_BIT];
         data_out <= s1_word;
      end else begin
         push_d0  <= 1'b0;
         push_d1  <= 1'b0;
         data_out <= '0;
      end
   end

   // --------------------------------------------------------------------------
   // Per-destination word counters; free-running wrap, no saturation.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (flush) begin
         cnt_d0 <= '0;
         cnt_d1 <= '0;
      end else begin
         if (push_d0) begin
            cnt_d0 <= cnt_d0 + CNT_ONE;
         end
         if (push_d1) begin
            cnt_d1 <= cnt_d1 + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_arbiter
//
// Bench for vc_arbiter. A cycle table drives the raw FIFO flags and read data
// directly and lists the outputs expected in each cycle. Multi-cycle corner
// cases (priority order, counter wrap, abort by reset/init) use a small
// behavioural model of the two VC FIFOs: queues whose head is moved onto the
// registered read-data bus on the edge that follows a pop.
// -----------------------------------------------------------------------------
module tb_vc_arbiter;

   localparam int DW = 6;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          init;
   logic          empty_vc0;
   logic          empty_vc1;
   logic [DW-1:0] data_vc0;
   logic [DW-1:0] data_vc1;
   logic          almost_full_d0;
   logic          almost_full_d1;
   logic          pop_vc0;
   logic          pop_vc1;
   logic          push_d0;
   logic          push_d1;
   logic [DW-1:0] data_out;
   logic [1:0]    state;
   logic          idle;
   logic [CW-1:0] cnt_d0;
   logic [CW-1:0] cnt_d1;

   always #5 clk = ~clk;

   vc_arbiter #(
      .DATA_WIDTH (DW),
      .DEST_BIT   (4),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .empty_vc0      (empty_vc0),
      .empty_vc1      (empty_vc1),
      .data_vc0       (data_vc0),
      .data_vc1       (data_vc1),
      .almost_full_d0 (almost_full_d0),
      .almost_full_d1 (almost_full_d1),
      .pop_vc0        (pop_vc0),
      .pop_vc1        (pop_vc1),
      .push_d0        (push_d0),
      .push_d1        (push_d1),
      .data_out       (data_out),
      .state          (state),
      .idle           (idle),
      .cnt_d0         (cnt_d0),
      .cnt_d1         (cnt_d1)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Cycle table. ctl = {reset, init, empty_vc0, empty_vc1, af_d0, af_d1};
   // outs = {pop_vc0, pop_vc1, push_d0, push_d1}. Expected values are those
   // seen during the cycle, before the edge that ends it.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [5:0]    ctl;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          chk;
      logic [3:0]    outs;
      logic [DW-1:0] dout;
      logic [1:0]    st;
      logic          idl;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
   } vec_t;

   localparam int NVEC = 20;
   vec_t tbl[NVEC];

   task automatic apply_vec(input vec_t v, input int idx);
      reset          = v.ctl[5];
      init           = v.ctl[4];
      empty_vc0      = v.ctl[3];
      empty_vc1      = v.ctl[2];
      almost_full_d0 = v.ctl[1];
      almost_full_d1 = v.ctl[0];
      data_vc0       = v.d0;
      data_vc1       = v.d1;
      @(negedge clk);
      if (v.chk) begin
         check($sformatf("vec%0d pop_vc0", idx),  pop_vc0,  v.outs[3]);
         check($sformatf("vec%0d pop_vc1", idx),  pop_vc1,  v.outs[2]);
         check($sformatf("vec%0d push_d0", idx),  push_d0,  v.outs[1]);
         check($sformatf("vec%0d push_d1", idx),  push_d1,  v.outs[0]);
         check($sformatf("vec%0d data_out", idx), data_out, v.dout);
         check($sformatf("vec%0d state", idx),    state,    v.st);
         check($sformatf("vec%0d idle", idx),     idle,     v.idl);
         check($sformatf("vec%0d cnt_d0", idx),   cnt_d0,   v.c0);
         check($sformatf("vec%0d cnt_d1", idx),   cnt_d1,   v.c1);
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // VC FIFO model and observation logs
   // ---------------------------------------------------------------------------
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic          pop_src[$];
   int            pop_cyc[$];
   logic [DW-1:0] log_data[$];
   logic          log_d1[$];
   int            push_cyc[$];
   int            cyc = 0;
   int            both_pops = 0;

   logic          s_pop0, s_pop1, s_push0, s_push1;
   logic [1:0]    s_state;
   logic [CW-1:0] s_cnt0, s_cnt1;

   task automatic refresh_empty();
      empty_vc0 = (q0.size() == 0);
      empty_vc1 = (q1.size() == 0);
   endtask

   task automatic clear_logs();
      pop_src.delete();
      pop_cyc.delete();
      log_data.delete();
      log_d1.delete();
      push_cyc.delete();
   endtask

   task automatic model_cycle();
      @(negedge clk);
      cyc++;
      s_pop0  = pop_vc0;
      s_pop1  = pop_vc1;
      s_push0 = push_d0;
      s_push1 = push_d1;
      s_state = state;
      s_cnt0  = cnt_d0;
      s_cnt1  = cnt_d1;
      if (pop_vc0 && pop_vc1) both_pops++;
      if (pop_vc0 || pop_vc1) begin
         pop_src.push_back(pop_vc1);
         pop_cyc.push_back(cyc);
      end
      if (push_d0 || push_d1) begin
         log_data.push_back(data_out);
         log_d1.push_back(push_d1);
         push_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (s_pop0 && q0.size() > 0) data_vc0 = q0.pop_front();
      if (s_pop1 && q1.size() > 0) data_vc1 = q1.pop_front();
      refresh_empty();
   endtask

   task automatic reset_and_init();
      q0.delete();
      q1.delete();
      refresh_empty();
      almost_full_d0 = 1'b0;
      almost_full_d1 = 1'b0;
      reset = 1'b1;
      init  = 1'b1;
      repeat (2) model_cycle();
      reset = 1'b0;
      repeat (2) model_cycle();
      clear_logs();
   endtask

   // ---------------------------------------------------------------------------
   // Three words in each VC: checks order, back-to-back pops, 2-cycle latency
   // and routing by bit 4.
   // ---------------------------------------------------------------------------
   task automatic test_priority();
      logic          exp_src[6];
      logic [DW-1:0] exp_data[6];
`ifdef VC_ARB_ROUND_ROBIN_EN
      exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_data = '{6'h01, 6'h11, 6'h02, 6'h12, 6'h03, 6'h13};
`else
      exp_src  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_data = '{6'h01, 6'h02, 6'h03, 6'h11, 6'h12, 6'h13};
`endif
      reset_and_init();
      both_pops = 0;
      q0 = '{6'h01, 6'h02, 6'h03};
      q1 = '{6'h11, 6'h12, 6'h13};
      refresh_empty();
      repeat (14) model_cycle();
      check("prio pop count", pop_src.size(), 6);
      check("prio push count", log_data.size(), 6);
      check("prio double pop", both_pops, 0);
      for (int i = 0; i < 6; i++) begin
         if (i < pop_src.size()) begin
            check($sformatf("prio pop%0d src", i), pop_src[i], exp_src[i]);
            check($sformatf("prio pop%0d cycle", i), pop_cyc[i], pop_cyc[0] + i);
         end
         if (i < log_data.size() && i < pop_cyc.size()) begin
            check($sformatf("prio push%0d data", i), log_data[i], exp_data[i]);
            check($sformatf("prio push%0d dest", i), log_d1[i], exp_data[i][4]);
            check($sformatf("prio push%0d latency", i), push_cyc[i] - pop_cyc[i], 2);
         end
      end
      check("prio cnt_d0", s_cnt0, 3);
      check("prio cnt_d1", s_cnt1, 3);
      check("prio final state", s_state, 2);
   endtask

   // ---------------------------------------------------------------------------
   // 33 words to D0: counter wraps 31 -> 0 -> 1.
   // ---------------------------------------------------------------------------
   task automatic test_wrap();
      int bad_data = 0;
      int to_d1    = 0;
      reset_and_init();
      for (int i = 0; i < 33; i++) begin
         q0.push_back(DW'((i % 16) + 32 * (i % 2)));
      end
      refresh_empty();
      repeat (40) model_cycle();
      check("wrap push count", log_data.size(), 33);
      for (int i = 0; i < log_data.size(); i++) begin
         if (log_data[i] !== DW'((i % 16) + 32 * (i % 2))) bad_data++;
         if (log_d1[i] !== 1'b0) to_d1++;
      end
      check("wrap data order", bad_data, 0);
      check("wrap pushes to d1", to_d1, 0);
      check("wrap cnt_d0", s_cnt0, 1);
      check("wrap cnt_d1", s_cnt1, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Abort a word in flight with reset (use_init=0) or init low (use_init=1).
   // ---------------------------------------------------------------------------
   task automatic test_abort(input bit use_init);
      string tag   = use_init ? "init" : "reset";
      bit    found = 1'b0;
      reset_and_init();
      q0.push_back(6'h07);
      refresh_empty();
      repeat (6) model_cycle();
      check({tag, " single word pops"}, pop_src.size(), 1);
      check({tag, " prime cnt_d0"}, s_cnt0, 1);
      clear_logs();
      q0.push_back(6'h0B);
      refresh_empty();
      for (int i = 0; i < 8 && !found; i++) begin
         model_cycle();
         if (s_pop0) found = 1'b1;
      end
      check({tag, " pop issued"}, found, 1);
      if (use_init) init = 1'b0;
      else          reset = 1'b1;
      model_cycle();
      reset = 1'b0;
      model_cycle();
      check({tag, " push after abort"}, {s_push0, s_push1}, 0);
      check({tag, " state after abort"}, s_state, use_init ? 1 : 0);
      model_cycle();
      check({tag, " state recovering"}, s_state, 1);
      init = 1'b1;
      repeat (4) model_cycle();
      check({tag, " dropped word pushes"}, log_data.size(), 0);
      check({tag, " cnt_d0 cleared"}, s_cnt0, 0);
      check({tag, " cnt_d1 cleared"}, s_cnt1, 0);
      check({tag, " back to idle"}, s_state, 2);
   endtask

   initial begin
      //            ctl        d0     d1    chk   outs     dout   st    idl   c0     c1
      tbl[0]  = '{6'b100100, 6'h00, 6'h00, 1'b0, 4'b0000, 6'h00, 2'd0, 1'b0, 5'd0, 5'd0};
      tbl[1]  = '{6'b100100, 6'h00, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd0, 1'b0, 5'd0, 5'd0};
      tbl[2]  = '{6'b000100, 6'h00, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd0, 1'b0, 5'd0, 5'd0};
      tbl[3]  = '{6'b000100, 6'h00, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd1, 1'b0, 5'd0, 5'd0};
      tbl[4]  = '{6'b010100, 6'h00, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd1, 1'b0, 5'd0, 5'd0};
      // single word 6'b010011 from VC0 -> D1
      tbl[5]  = '{6'b010100, 6'h00, 6'h00, 1'b1, 4'b1000, 6'h00, 2'd2, 1'b1, 5'd0, 5'd0};
      tbl[6]  = '{6'b011100, 6'h13, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd3, 1'b0, 5'd0, 5'd0};
      tbl[7]  = '{6'b011100, 6'h13, 6'h00, 1'b1, 4'b0001, 6'h13, 2'd3, 1'b0, 5'd0, 5'd0};
      tbl[8]  = '{6'b011100, 6'h13, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd2, 1'b1, 5'd0, 5'd1};
      // two pops, then almost_full_d0 / almost_full_d1 block further pops
      tbl[9]  = '{6'b010100, 6'h13, 6'h00, 1'b1, 4'b1000, 6'h00, 2'd2, 1'b1, 5'd0, 5'd1};
      tbl[10] = '{6'b010100, 6'h05, 6'h00, 1'b1, 4'b1000, 6'h00, 2'd3, 1'b0, 5'd0, 5'd1};
      tbl[11] = '{6'b010110, 6'h06, 6'h00, 1'b1, 4'b0010, 6'h05, 2'd3, 1'b0, 5'd0, 5'd1};
      tbl[12] = '{6'b010110, 6'h06, 6'h00, 1'b1, 4'b0010, 6'h06, 2'd3, 1'b0, 5'd1, 5'd1};
      tbl[13] = '{6'b010101, 6'h06, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd3, 1'b0, 5'd2, 5'd1};
      tbl[14] = '{6'b011100, 6'h06, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd3, 1'b0, 5'd2, 5'd1};
      tbl[15] = '{6'b011100, 6'h06, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd2, 1'b1, 5'd2, 5'd1};
      // VC1 alone: word 6'h3A (bit4=1) -> D1 via data_vc1
      tbl[16] = '{6'b011000, 6'h00, 6'h00, 1'b1, 4'b0100, 6'h00, 2'd2, 1'b1, 5'd2, 5'd1};
      tbl[17] = '{6'b011100, 6'h00, 6'h3A, 1'b1, 4'b0000, 6'h00, 2'd3, 1'b0, 5'd2, 5'd1};
      tbl[18] = '{6'b011100, 6'h00, 6'h3A, 1'b1, 4'b0001, 6'h3A, 2'd3, 1'b0, 5'd2, 5'd1};
      tbl[19] = '{6'b011100, 6'h00, 6'h00, 1'b1, 4'b0000, 6'h00, 2'd2, 1'b1, 5'd2, 5'd2};

      reset          = 1'b1;
      init           = 1'b0;
      empty_vc0      = 1'b0;
      empty_vc1      = 1'b1;
      almost_full_d0 = 1'b0;
      almost_full_d1 = 1'b0;
      data_vc0       = '0;
      data_vc1       = '0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         apply_vec(tbl[i], i);
      end

      test_priority();
      test_wrap();
      test_abort(1'b0);
      test_abort(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Downstream consumer of the two virtual-channel FIFOs (VC0, VC1); pops their heads, captures the read data and routes each word to one of two destination FIFOs (D0/D1) selected by a destination bit in the word.
- Sits between the VC FIFO pair and the destination FIFO pair in the transmit path.
- Applies back-pressure from the destination almost-full flags.
- Keeps per-destination word counters for the checker.

Parameters:
- DATA_WIDTH, 6, word width; matches the VC FIFO data width.
- DEST_BIT, 4, bit index of the word that selects the destination (0 → D0, 1 → D1).
- CNT_WIDTH, 5, width of the per-destination word counters.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high; sampled only on posedge clk.
- init  in  1  low = hold in INIT and flush; high = normal operation.
- empty_vc0  in  1  VC0 FIFO empty flag.
- empty_vc1  in  1  VC1 FIFO empty flag.
- data_vc0  in  DATA_WIDTH  VC0 FIFO registered read data, valid the cycle after its rd_enable.
- data_vc1  in  DATA_WIDTH  VC1 FIFO registered read data, same timing as data_vc0.
- almost_full_d0  in  1  D0 destination FIFO almost-full flag.
- almost_full_d1  in  1  D1 destination FIFO almost-full flag.
- pop_vc0  out  1  rd_enable to VC0 (combinational).
- pop_vc1  out  1  rd_enable to VC1 (combinational).
- push_d0  out  1  wr_enable to D0 (registered).
- push_d1  out  1  wr_enable to D1 (registered).
- data_out  out  DATA_WIDTH  word to destination FIFOs (registered).
- state  out  2  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- idle  out  1  high in IDLE with nothing in flight.
- cnt_d0  out  CNT_WIDTH  words pushed to D0, wraps.
- cnt_d1  out  CNT_WIDTH  words pushed to D1, wraps.

Behaviour:
- Reset (reset=1 at posedge):
  - state=RESET.
  - push_d0, push_d1, data_out, cnt_d0, cnt_d1 and internal pipeline valid/select all cleared to 0.
  - idle=0.
  - pop_vc0=pop_vc1=0 while state is RESET or INIT.
  - Reset asserted mid-operation drops all in-flight words; no push is produced for them.
- FSM, checked in priority order:
  - reset=1 → RESET from any state.
  - init=0 → INIT from any state; the pipeline is flushed and the counters are cleared, as on reset.
  - RESET → INIT when reset=0.
  - INIT → IDLE when init=1.
  - IDLE → ACTIVE when either empty flag is low.
  - ACTIVE → IDLE when both empty flags are high and no word is in flight (stage-1 valid=0).
- Pop eligibility (state IDLE or ACTIVE):
  - go = !almost_full_d0 && !almost_full_d1.
  - Both destination flags are checked because the destination is unknown before the pop.
- Pop priority:
  - Strict priority: pop_vc0 = go && !empty_vc0.
  - pop_vc1 = go && empty_vc0 && !empty_vc1.
  - At most one pop per cycle; back-to-back pops are allowed every cycle.
- Pipeline:
  - Cycle N: pop issued.
  - N+1: s1_valid=1, s1_sel=source.
  - At edge N+1→N+2: data_out <= s1_sel ? data_vc1 : data_vc0.
  - push_d0 <= s1_valid && !word[DEST_BIT]; push_d1 <= s1_valid && word[DEST_BIT].
  - Latency pop→push = 2 cycles. Exactly one of push_d0/push_d1 is high per transferred word.
  - push and data_out return to 0 on cycles with no transfer.
- Counters: cnt_dX increments on each cycle its push_dX is high. Wrap from 2^CNT_WIDTH-1 to 0 with no saturation.
- Back-pressure margin:
  - Up to 2 words may be in flight when almost-full rises.
  - Destination almost-full thresholds shall leave ≥2 free slots.
  - The arbiter never drops a word.
- Empty boundary: a single word in a VC FIFO produces exactly one pop. The empty flag rises the following cycle and no further pop is issued.
- idle = (state==IDLE) && !s1_valid && !push_d0 && !push_d1.

Optional Feature:
- Macro: VC_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both VCs are non-empty and go=1, pops alternate VC0, VC1, VC0, …
  - A last-served register, reset to VC1, makes VC0 win first.
  - A single non-empty VC is served every cycle.
- Undefined: strict VC0 priority as described in Behaviour.

Test Plan:
- Reset: reset=1 for 2 cycles, then reset=0, init=0 → state=0 then 1; all outputs 0; no pops even with empty_vc0=0.
- Single word: init=1, VC0 holds 6'b010011 (DEST_BIT=1) → pop_vc0 at N; push_d1=1 with data_out=6'b010011 at N+2; cnt_d1=1; push_d0 stays 0.
- Priority and back-pressure:
  - Both VCs hold 3 words each → 3 VC0 pops, then 3 VC1 pops, on consecutive cycles; with VC_ARB_ROUND_ROBIN_EN the order is 0,1,0,1,0,1.
  - Raising almost_full_d0 mid-stream stops pops the next cycle; the 2 in-flight words are still pushed.
- Routing and wrap: 33 words to D0 (bit4=0) → cnt_d0 wraps to 1; cnt_d1=0.
- Reset/init mid-operation: reset=1 one cycle after a pop → no push for that word; counters 0. Repeating with init=0 instead gives the same result, with state=1.
